// File: rtl/ecc_75_rd_post.sv
// ---------------------------------------------------------------------------
// ecc_75_rd_post
//   Downstream stage of the 75-bit ECC fault-detecting decoder on the FIFO
//   read path. It registers each corrected read beat and its error flags into
//   a single valid/ready output register with full throughput. It keeps
//   saturating sbit/dbit/fault counters and a sticky error interrupt, and can
//   optionally log the first failing address.
//
//   Optional feature: define ECC_RD_POST_LOG_EN to build the error log FSM.
//   Without it the log_* outputs are tied to zero, but the ports remain.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   in_vld/in_rdy          decoder beat handshake
//   in_addr, in_data       read address and corrected data of the beat
//   in_sbit_err/dbit/fault error flags reported by the decoder
//   out_vld/out_rdy        consumer handshake
//   out_data, out_err      registered beat, out_err = {fault, dbit, sbit}
//   sbit_irq_en            single-bit errors also raise err_irq
//   err_clr                clears the counters, the interrupt and the log
//   sbit/dbit/fault_cnt    saturating counts of accepted flagged beats
//   err_irq                sticky error interrupt
//   log_vld/ovf/addr/type  first qualifying error capture plus overflow flag
// ---------------------------------------------------------------------------
module ecc_75_rd_post #(
  parameter int DATA_WIDTH = 75,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sbit_err,
  input  logic                  in_dbit_err,
  input  logic                  in_ecc_fault,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_err,
  input  logic                  sbit_irq_en,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic                  err_irq,
  output logic                  log_vld,
  output logic                  log_ovf,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic [2:0]            log_type
);

  logic                  acc;
  logic                  qual;
  logic [2:0]            inErr;

  logic                  outVld_q;
  logic [DATA_WIDTH-1:0] outData_q;
  logic [2:0]            outErr_q;
  logic [CNT_WIDTH-1:0]  sbitCnt_q, sbitCnt_d;
  logic [CNT_WIDTH-1:0]  dbitCnt_q, dbitCnt_d;
  logic [CNT_WIDTH-1:0]  faultCnt_q, faultCnt_d;
  logic                  errIrq_q, errIrq_d;

  // The output register frees up in the same cycle the consumer takes the
  // current beat, so a new beat can be accepted every cycle.
  assign in_rdy = ~outVld_q | out_rdy;
  assign acc    = in_vld & in_rdy;
  assign inErr  = {in_ecc_fault, in_dbit_err, in_sbit_err};
  // A qualifying error both sets the interrupt and is a candidate for the log.
  assign qual   = acc & (in_dbit_err | in_ecc_fault | (in_sbit_err & sbit_irq_en));

  // Saturating counter update. A clear in the same cycle as a hit restarts
  // the count at 1, so that the hit is not lost.
  function automatic logic [CNT_WIDTH-1:0] cntNext(input logic [CNT_WIDTH-1:0] cur,
                                                   input logic hit, input logic clr);
    if (clr) return hit ? CNT_WIDTH'(1) : '0;
    if (hit && (cur != '1)) return cur + CNT_WIDTH'(1);
    return cur;
  endfunction

  // Next-state for the counters and the interrupt. If set and clear arrive
  // together, set wins.
  always_comb begin
    sbitCnt_d  = cntNext(sbitCnt_q,  acc & in_sbit_err,  err_clr);
    dbitCnt_d  = cntNext(dbitCnt_q,  acc & in_dbit_err,  err_clr);
    faultCnt_d = cntNext(faultCnt_q, acc & in_ecc_fault, err_clr);
    errIrq_d   = qual | (errIrq_q & ~err_clr);
  end

  // Output register. The beat is held while the consumer stalls. A reset
  // drops any pending beat. err_clr never touches this path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outVld_q  <= 1'b0;
      outData_q <= '0;
      outErr_q  <= '0;
    end else if (acc) begin
      outVld_q  <= 1'b1;
      outData_q <= in_data;
      outErr_q  <= inErr;
    end else if (out_rdy) begin
      outVld_q  <= 1'b0;
    end
  end

  // Error counters and the sticky interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sbitCnt_q  <= '0;
      dbitCnt_q  <= '0;
      faultCnt_q <= '0;
      errIrq_q   <= 1'b0;
    end else begin
      sbitCnt_q  <= sbitCnt_d;
      dbitCnt_q  <= dbitCnt_d;
      faultCnt_q <= faultCnt_d;
      errIrq_q   <= errIrq_d;
    end
  end

  assign out_vld   = outVld_q;
  assign out_data  = outData_q;
  assign out_err   = outErr_q;
  assign sbit_cnt  = sbitCnt_q;
  assign dbit_cnt  = dbitCnt_q;
  assign fault_cnt = faultCnt_q;
  assign err_irq   = errIrq_q;

`ifdef ECC_RD_POST_LOG_EN
  typedef enum logic [1:0] {L_IDLE, L_HELD, L_OVF} logState_e;

  logState_e             logState_q, logState_d;
  logic [ADDR_WIDTH-1:0] logAddr_q, logAddr_d;
  logic [2:0]            logType_q, logType_d;

  // Log next-state logic. The first qualifying error is captured and later
  // ones only mark overflow. A clear that coincides with a qualifying beat
  // restarts the log holding that beat.
  always_comb begin
    logState_d = logState_q;
    logAddr_d  = logAddr_q;
    logType_d  = logType_q;
    if (err_clr) begin
      if (qual) begin
        logState_d = L_HELD;
        logAddr_d  = in_addr;
        logType_d  = inErr;
      end else begin
        logState_d = L_IDLE;
        logAddr_d  = '0;
        logType_d  = '0;
      end
    end else begin
      case (logState_q)
        L_IDLE: if (qual) begin
          logState_d = L_HELD;
          logAddr_d  = in_addr;
          logType_d  = inErr;
        end
        L_HELD: if (qual) logState_d = L_OVF;
        L_OVF:  ;
        default: logState_d = L_IDLE;
      endcase
    end
  end

  // Log state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      logState_q <= L_IDLE;
      logAddr_q  <= '0;
      logType_q  <= '0;
    end else begin
      logState_q <= logState_d;
      logAddr_q  <= logAddr_d;
      logType_q  <= logType_d;
    end
  end

  assign log_vld  = (logState_q != L_IDLE);
  assign log_ovf  = (logState_q == L_OVF);
  assign log_addr = logAddr_q;
  assign log_type = logType_q;
`else
  // Without the log, the beat address has no consumer.
  logic unusedAddr;
  assign unusedAddr = ^in_addr;

  assign log_vld  = 1'b0;
  assign log_ovf  = 1'b0;
  assign log_addr = '0;
  assign log_type = '0;
`endif

endmodule

// File: tb/tb_ecc_75_rd_post.sv
// ---------------------------------------------------------------------------
// tb_ecc_75_rd_post
//   Scoreboard bench for ecc_75_rd_post, built with CNT_WIDTH=4 so that
//   counter saturation can be reached quickly. A reference model predicts
//   each accepted beat and pushes it into a queue. A separate monitor pops
//   from the queue whenever the DUT hands a beat to the consumer. The model
//   also tracks the counters, the interrupt and the log.
// ---------------------------------------------------------------------------
module tb_ecc_75_rd_post;
  localparam int DW = 75;
  localparam int AW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_sbit_err = 1'b0;
  logic          in_dbit_err = 1'b0;
  logic          in_ecc_fault = 1'b0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_data;
  logic [2:0]    out_err;
  logic          sbit_irq_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic          err_irq;
  logic          log_vld, log_ovf;
  logic [AW-1:0] log_addr;
  logic [2:0]    log_type;

  int checks = 0;
  int errors = 0;

  ecc_75_rd_post #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_addr(in_addr), .in_data(in_data), .in_sbit_err(in_sbit_err),
    .in_dbit_err(in_dbit_err), .in_ecc_fault(in_ecc_fault),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_err(out_err),
    .sbit_irq_en(sbit_irq_en), .err_clr(err_clr),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
    .err_irq(err_irq), .log_vld(log_vld), .log_ovf(log_ovf),
    .log_addr(log_addr), .log_type(log_type)
  );

  always #5 clk = ~clk;

  // Expected beats as {data, err}, oldest first.
  logic [DW+2:0] expQ[$];

  // Reference model state, i.e. the values expected right after the last edge.
  bit       mVld = 0;
  int       mSbit = 0, mDbit = 0, mFault = 0;
  bit       mIrq = 0;
  bit       mLogVld = 0, mLogOvf = 0;
  int       mLogAddr = 0, mLogType = 0;
  localparam int CNT_MAX = (1 << CW) - 1;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance a saturating counter by one event, optionally after a clear.
  function automatic int countStep(input int cur, input bit hit, input bit clr);
    int base = clr ? 0 : cur;
    if (hit) return (base + 1 > CNT_MAX) ? CNT_MAX : base + 1;
    return base;
  endfunction

  // Model. Each falling edge compares the DUT with the expected state after
  // the previous edge, then predicts the outcome of the coming rising edge
  // from the inputs that are currently applied.
  always @(negedge clk) begin
    bit acc, qual, expRdy;
    logic [2:0] flags;
    expRdy = !mVld || out_rdy;
    checkOutput("in_rdy", in_rdy, expRdy);
    checkOutput("out_vld", out_vld, mVld);
    checkOutput("sbit_cnt", sbit_cnt, mSbit[CW-1:0]);
    checkOutput("dbit_cnt", dbit_cnt, mDbit[CW-1:0]);
    checkOutput("fault_cnt", fault_cnt, mFault[CW-1:0]);
    checkOutput("err_irq", err_irq, mIrq);
`ifdef ECC_RD_POST_LOG_EN
    checkOutput("log_vld", log_vld, mLogVld);
    checkOutput("log_ovf", log_ovf, mLogOvf);
    checkOutput("log_addr", log_addr, mLogAddr[AW-1:0]);
    checkOutput("log_type", log_type, mLogType[2:0]);
`else
    checkOutput("log_vld", log_vld, 0);
    checkOutput("log_ovf", log_ovf, 0);
    checkOutput("log_addr", log_addr, 0);
    checkOutput("log_type", log_type, 0);
`endif
    if (!rst_n) begin
      mVld = 0; mSbit = 0; mDbit = 0; mFault = 0; mIrq = 0;
      mLogVld = 0; mLogOvf = 0; mLogAddr = 0; mLogType = 0;
      expQ.delete();
    end else begin
      flags = {in_ecc_fault, in_dbit_err, in_sbit_err};
      acc  = in_vld && expRdy;
      qual = acc && (in_dbit_err || in_ecc_fault || (in_sbit_err && sbit_irq_en));
      if (acc) begin
        expQ.push_back({in_data, flags});
        mVld = 1;
      end else if (out_rdy) begin
        mVld = 0;
      end
      mSbit  = countStep(mSbit,  acc && in_sbit_err,  err_clr);
      mDbit  = countStep(mDbit,  acc && in_dbit_err,  err_clr);
      mFault = countStep(mFault, acc && in_ecc_fault, err_clr);
      mIrq   = qual || (mIrq && !err_clr);
      if (err_clr) begin
        mLogVld = qual; mLogOvf = 0;
        mLogAddr = qual ? int'(in_addr) : 0;
        mLogType = qual ? int'(flags) : 0;
      end else if (qual) begin
        if (!mLogVld) begin
          mLogVld = 1; mLogAddr = int'(in_addr); mLogType = int'(flags);
        end else begin
          mLogOvf = 1;
        end
      end
    end
  end

  // Monitor. It pops one expected beat each time the consumer takes one.
  always @(negedge clk) begin
    logic [DW+2:0] e;
    if (rst_n && out_vld && out_rdy) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedBeat", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_data", out_data, e[DW+2:3]);
        checkOutput("out_err", out_err, e[2:0]);
      end
    end
  end

  task automatic applyStimulus(input bit vld, input logic [AW-1:0] addr, input bit s,
                               input bit d, input bit f, input bit ordy, input bit en,
                               input bit clr, input bit rn);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    in_vld = vld; in_addr = addr; in_data = r[DW-1:0];
    in_sbit_err = s; in_dbit_err = d; in_ecc_fault = f;
    out_rdy = ordy; sbit_irq_en = en; err_clr = clr; rst_n = rn;
    @(posedge clk); #1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Clean beats with the consumer always ready.
    for (int i = 0; i < 4; i++) applyStimulus(1, AW'(i), 0, 0, 0, 1, 0, 0, 1);
    // Single-bit error, first without and then with interrupt enable.
    applyStimulus(1, 8'h12, 1, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    applyStimulus(1, 8'h12, 1, 0, 0, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1);
    // Backpressure: the held beat must stay put while a new beat waits.
    applyStimulus(1, 8'h20, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'h21, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 8'h21, 0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    // dbit then fault: first capture wins, the second sets overflow.
    applyStimulus(1, 8'h05, 0, 1, 0, 1, 0, 0, 1);
    applyStimulus(1, 8'h06, 0, 0, 1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    // Saturate the sbit counter, then clear together with an sbit beat.
    for (int i = 0; i < 20; i++) applyStimulus(1, AW'(i), 1, 0, 0, 1, 0, 0, 1);
    applyStimulus(1, 8'h30, 1, 0, 0, 1, 0, 1, 1);
    // Clear together with a dbit beat: the interrupt stays set and the log holds the new beat.
    applyStimulus(1, 8'h40, 0, 1, 0, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    // Random traffic, including a reset in the middle of the stream.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(9, 0) < 7, AW'($urandom),
                    $urandom_range(4, 0) == 0, $urandom_range(6, 0) == 0,
                    $urandom_range(7, 0) == 0, $urandom_range(9, 0) < 7,
                    $urandom_range(1, 0) == 1, $urandom_range(19, 0) == 0,
                    !(i == 200 || i == 201));
    end
    // Drain any remaining beats.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
